writeback_stage: RTL and testbench

- Registered writeback stage of the RISC-V core; successor to the fixed 3-input result select.
- Captures MEM-stage results through a valid/ready pipeline register, then selects ALU result, aligned and extended load data, PC+4 or immediate.
- Drives register-file write port (rd, data, write enable) and flags misaligned loads.
- PC width is generic, not a fixed 16 bits.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/load_extend.sv | 52 +++++
 rtl/writeback_stage.sv | 160 ++++++++++++++++
 tb/tb_writeback_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: result-source encoding
// and the load funct3 codes understood by load_extend.
package wb_pkg;

  typedef enum logic [2:0] {
    RES_ALU  = 3'b000,
    RES_LOAD = 3'b001,
    RES_PC4  = 3'b010,
    RES_IMM  = 3'b011
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic is_half_load(input logic [2:0] f3);
    return (f3 == F3_LH) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data alignment: picks the byte/halfword lane addressed by
// addr_i, sign- or zero-extends it, and flags misaligned halfword/word loads.
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension
  always_comb begin
    byte_s = 8'h00;
    case (addr_i)
      2'b00:   byte_s = word_i[7:0];
      2'b01:   byte_s = word_i[15:8];
      2'b10:   byte_s = word_i[23:16];
      2'b11:   byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    // Halfword offset comes from addr[1] only; addr[0] is the misalignment case.
    if (addr_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  data_o = {24'h000000, byte_s};
      F3_LH:   data_o = {{16{half_s[15]}}, half_s};
      F3_LHU:  data_o = {16'h0000, half_s};
      default: data_o = word_i;
    endcase
  end

  // Misalignment detection
  always_comb begin
    if (is_half_load(funct3_i)) begin
      misaligned_o = addr_i[0];
    end else if (funct3_i == F3_LW) begin
      misaligned_o = (addr_i != 2'b00);
    end else begin
      misaligned_o = 1'b0;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Registered writeback stage: valid/ready pipeline register feeding the
// register-file write port. Define WB_RETIRE_COUNT_EN to add the instret counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     ALU_result,
  input  logic [DATA_WIDTH-1:0]     ReadData,
  input  logic [PC_WIDTH-1:0]       PC,
  input  logic [DATA_WIDTH-1:0]     ImmExt,
  input  logic [2:0]                ResultSrc,
  input  logic [2:0]                funct3,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      RegWrite,
  input  logic                      out_ready,
  output logic                      wb_valid,
  output logic                      wb_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      load_misaligned
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]               instret
`endif
);

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     alu_q, alu_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic [2:0]                src_q, src_d;
  logic [2:0]                f3_q, f3_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      rw_q, rw_d;

  logic [31:0]               load_data_s;
  logic                      load_mis_s;
  logic [PC_WIDTH-1:0]       pc4_s;
  logic [DATA_WIDTH-1:0]     result_s;

  assign in_ready = !valid_q || out_ready;

  // Next-state: flush beats capture; a stalled register holds every field
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    src_d   = src_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      alu_d   = ALU_result;
      rdata_d = ReadData;
      pc_d    = PC;
      imm_d   = ImmExt;
      src_d   = ResultSrc;
      f3_d    = funct3;
      rd_d    = rd;
      rw_d    = RegWrite;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      src_q   <= 3'b000;
      f3_q    <= 3'b000;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      src_q   <= src_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end

  load_extend u_load_extend (
    .word_i      (rdata_q[31:0]),
    .addr_i      (alu_q[1:0]),
    .funct3_i    (f3_q),
    .data_o      (load_data_s),
    .misaligned_o(load_mis_s)
  );

  assign pc4_s = pc_q + PC_WIDTH'(4);

  // Result select; 1xx encodings fall back to the ALU result
  always_comb begin
    case (src_q)
      RES_ALU:  result_s = alu_q;
      RES_LOAD: result_s = DATA_WIDTH'(load_data_s);
      RES_PC4:  result_s = DATA_WIDTH'(pc4_s);
      RES_IMM:  result_s = imm_q;
      default:  result_s = alu_q;
    endcase
  end

  // Write-port drive; idle port shows zeros
  always_comb begin
    wb_valid = valid_q;
    if (valid_q) begin
      wb_rd           = rd_q;
      wb_data         = result_s;
      load_misaligned = (src_q == RES_LOAD) && load_mis_s;
    end else begin
      wb_rd           = '0;
      wb_data         = '0;
      load_misaligned = 1'b0;
    end
    wb_we = valid_q && out_ready && rw_q && (wb_rd != '0) && !load_misaligned;
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] instret_q;

  // Retirement counter: every consumed instruction, writing or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else if (valid_q && out_ready) begin
      instret_q <= instret_q + 64'd1;
    end else begin
      instret_q <= instret_q;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage (PC_WIDTH=16 build); expected
// results come from an arithmetic reference model of the load/select rules.
module tb_writeback_stage;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        rw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [31:0] ALU_result = 32'd0, ReadData = 32'd0, ImmExt = 32'd0;
  logic [15:0] PC = 16'd0;
  logic [2:0]  ResultSrc = 3'd0, funct3 = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic        RegWrite = 1'b0, out_ready = 1'b1;
  logic        wb_valid, wb_we, load_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] instret;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   mv = 1'b0;
  longint unsigned retired = 0;

  writeback_stage #(.DATA_WIDTH(32), .PC_WIDTH(16), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .ALU_result(ALU_result), .ReadData(ReadData), .PC(PC), .ImmExt(ImmExt),
    .ResultSrc(ResultSrc), .funct3(funct3), .rd(rd), .RegWrite(RegWrite),
    .out_ready(out_ready), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .load_misaligned(load_misaligned)
`ifdef WB_RETIRE_COUNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lane picked by shifting, sign extension by arithmetic
  function automatic exp_t model(input logic [2:0] src, input logic [31:0] alu,
                                 input logic [31:0] rdata, input logic [15:0] pc,
                                 input logic [31:0] imm, input logic [2:0] f3,
                                 input logic [4:0] rdv, input logic rw);
    exp_t e;
    int unsigned lane = alu[1:0];
    int unsigned hoff = alu[1] ? 16 : 0;
    logic [31:0] b = (rdata >> (8 * lane)) & 32'hFF;
    logic [31:0] h = (rdata >> hoff) & 32'hFFFF;
    logic [31:0] ld;
    case (f3)
      3'd0:    ld = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd4:    ld = b;
      3'd1:    ld = (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd5:    ld = h;
      default: ld = rdata;
    endcase
    case (src)
      3'd1:    e.data = ld;
      3'd2:    e.data = (32'(pc) + 32'd4) % 32'd65536;
      3'd3:    e.data = imm;
      default: e.data = alu;
    endcase
    e.mis = (src == 3'd1) && ((((f3 == 3'd1) || (f3 == 3'd5)) && alu[0]) ||
                              ((f3 == 3'd2) && (alu[1:0] != 2'd0)));
    e.rd = rdv;
    e.rw = rw;
    return e;
  endfunction

  // Monitor: compare presented outputs against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      bit ev;
      ev = (sb.size() != 0);
      check("wb_valid", 64'(wb_valid), 64'(ev));
      check("in_ready", 64'(in_ready), 64'(!ev || out_ready));
`ifdef WB_RETIRE_COUNT_EN
      check("instret", instret, 64'(retired));
`endif
      if (ev) begin
        exp_t e;
        e = sb[0];
        check("wb_data", 64'(wb_data), 64'(e.data));
        check("wb_rd", 64'(wb_rd), 64'(e.rd));
        check("load_misaligned", 64'(load_misaligned), 64'(e.mis));
        check("wb_we", 64'(wb_we), 64'(out_ready && e.rw && (e.rd != 5'd0) && !e.mis));
        if (out_ready) begin
          void'(sb.pop_front());
          retired++;
        end
      end else begin
        check("idle_data", 64'(wb_data), 64'd0);
        check("idle_rd", 64'(wb_rd), 64'd0);
        check("idle_we", 64'(wb_we), 64'd0);
      end
    end
  end

  // Advance one clock, updating the stage-occupancy model at the edge
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin
        if (mv && !out_ready) void'(sb.pop_front());
        mv = 1'b0;
      end else if (in_valid && (!mv || out_ready)) begin
        sb.push_back(model(ResultSrc, ALU_result, ReadData, PC, ImmExt, funct3, rd, RegWrite));
        mv = 1'b1;
      end else if (out_ready) begin
        mv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic send(input logic v, input logic [2:0] src, input logic [31:0] alu,
                      input logic [31:0] rdata, input logic [15:0] pc, input logic [2:0] f3,
                      input logic [4:0] rdv, input logic rw, input logic ordy, input logic fl);
    in_valid = v; ResultSrc = src; ALU_result = alu; ReadData = rdata; PC = pc;
    ImmExt = alu ^ 32'hA5A5_0000; funct3 = f3; rd = rdv; RegWrite = rw;
    out_ready = ordy; flush = fl;
    step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_we"}, 64'(wb_we), 64'd0);
    check({tag, "_rd"}, 64'(wb_rd), 64'd0);
    check({tag, "_data"}, 64'(wb_data), 64'd0);
    check({tag, "_mis"}, 64'(load_misaligned), 64'd0);
  endtask

  initial begin
    #22;
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(1'b1, 3'b000, 32'h12345678, 32'h0, 16'h0, 3'b010, 5'd5, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b001, 32'h00001003, 32'h80FF7F01, 16'h0, 3'b000, 5'd6, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b001, 32'h00001003, 32'h80FF7F01, 16'h0, 3'b100, 5'd7, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b001, 32'h00001002, 32'h80FF7F01, 16'h0, 3'b101, 5'd8, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b001, 32'h00001001, 32'hDEADBEEF, 16'h0, 3'b010, 5'd9, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b001, 32'h00001001, 32'hDEADBEEF, 16'h0, 3'b001, 5'd10, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b001, 32'h00001002, 32'hDEADBEEF, 16'h0, 3'b001, 5'd11, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b010, 32'h0, 32'h0, 16'hFFFE, 3'b000, 5'd12, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b010, 32'h0, 32'h0, 16'hFFFF, 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b011, 32'h0F0F0F0F, 32'h0, 16'h0, 3'b000, 5'd13, 1'b1, 1'b1, 1'b0);
    send(1'b1, 3'b110, 32'hCAFEF00D, 32'h1, 16'h0, 3'b000, 5'd14, 1'b1, 1'b1, 1'b0);
    // Backpressure: held instruction stays put while a new one waits
    for (int i = 0; i < 3; i++)
      send(1'b1, 3'b000, 32'h0BAD0000 + 32'(i), 32'h0, 16'h0, 3'b000, 5'd15, 1'b1, 1'b0, 1'b0);
    send(1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);
    send(1'b1, 3'b000, 32'h77777777, 32'h0, 16'h0, 3'b000, 5'd16, 1'b1, 1'b1, 1'b1);
    send(1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);
    // Reset while holding discards the instruction at once
    send(1'b1, 3'b000, 32'h55AA55AA, 32'h0, 16'h0, 3'b000, 5'd17, 1'b1, 1'b0, 1'b0);
    send(1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sb.delete();
    mv = 1'b0;
    retired = 0;
    step();
    rst_n = 1'b1;
    send(1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] alu;
      alu = {$urandom_range(0, 32'hFFFF), 14'h0, 2'($urandom_range(0, 3))} ^ {$urandom, 2'b00};
      send(1'b1 && ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), alu, $urandom,
           16'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 3; i++)
      send(1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
